// File: rtl/tdm_pkg.sv
// Shared TDM link definitions, used by the receive demux and the future transmit mux.
package tdm_pkg;

   localparam int unsigned N_SLOTS = 4;
   localparam int unsigned SLOT_W  = 2;

   typedef logic [SLOT_W-1:0] slot_t;

   localparam slot_t SLOT0 = 2'd0;
   localparam slot_t SLOT1 = 2'd1;
   localparam slot_t SLOT2 = 2'd2;
   localparam slot_t SLOT3 = 2'd3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Rotating TDM slot index: loads 1 on sync (sync sample occupies slot 0), else steps on en.
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  load,
   output slot_t slot,
   output logic  last_slot
);

   // Slot register; wraps 3 -> 0 naturally through the 2-bit add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= SLOT0;
      end else if (load) begin
         slot <= SLOT1;
      end else if (en) begin
         slot <= slot + slot_t'(1);
      end
   end

   assign last_slot = (slot == SLOT3);

endmodule

// File: rtl/tdm_demux_1a4.sv
// Receive end of a 4-slot TDM link: steers samples into staging and publishes whole frames.
module tdm_demux_1a4
   import tdm_pkg::*;
#(
   parameter int unsigned W = 1
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sync,
   input  logic [W-1:0]         x,
   input  logic                 clr_err,
   output logic [N_SLOTS*W-1:0] y,
   output logic                 frame_valid,
   output logic                 locked,
   output logic [SLOT_W-1:0]    slot,
   output logic                 sync_err
);

   logic [N_SLOTS-2:0][W-1:0] staging;
   logic                      last_slot;
   logic                      sync_acc;
   logic                      plain_acc;
   logic                      frame_done;
   logic                      misplaced;

   // Accepted-sample qualifiers; plain samples before the first sync are dropped.
   always_comb begin
      sync_acc   = en && sync;
      plain_acc  = en && !sync && locked;
      frame_done = plain_acc && last_slot;
      misplaced  = sync_acc && locked && (slot != SLOT0);
   end

   tdm_slot_counter u_slot_counter (
      .clk       (clk),
      .rst       (rst),
      .en        (plain_acc),
      .load      (sync_acc),
      .slot      (slot),
      .last_slot (last_slot)
   );

   // Staging for slots 0..2; the slot-3 sample goes straight into the frame output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         staging <= '0;
      end else if (sync_acc) begin
         staging[0] <= x;
      end else if (plain_acc) begin
         for (int unsigned k = 0; k < N_SLOTS - 1; k++) begin
            if (slot == SLOT_W'(k)) begin
               staging[k] <= x;
            end
         end
      end
   end

   // Atomic frame transfer with a single-cycle strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y           <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         if (frame_done) begin
            y <= {x, staging};
         end
      end
   end

   // Lock is gained on the first sync and held until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked <= 1'b0;
      end else if (sync_acc) begin
         locked <= 1'b1;
      end
   end

   // Sticky misplaced-sync flag; a new error beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_err <= 1'b0;
      end else if (misplaced) begin
         sync_err <= 1'b1;
      end else if (clr_err) begin
         sync_err <= 1'b0;
      end
   end

endmodule
